// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive controller:
//   - register byte offsets (DATA, STAT, CTRL, CLR)
//   - bit positions inside STAT, CTRL and CLR
//   - bus handshake FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

    // Register byte offsets; address bits [1:0] are don't-care.
    localparam logic [3:0] OFF_DATA = 4'h0;
    localparam logic [3:0] OFF_STAT = 4'h4;
    localparam logic [3:0] OFF_CTRL = 4'h8;
    localparam logic [3:0] OFF_CLR  = 4'hC;

    // DATA read layout
    localparam int DATA_VALID   = 8;

    // STAT bits
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVR     = 2;
    localparam int STAT_TO      = 3;
    localparam int STAT_CNT_LSB = 8;
    localparam int CNT_FIELD_W  = 7;

    // CTRL bits
    localparam int CTRL_RX_EN   = 0;
    localparam int CTRL_THR_IE  = 1;
    localparam int CTRL_OVR_IE  = 2;
    localparam int CTRL_TO_IE   = 3;
    localparam int CTRL_THR_LSB = 8;

    // CLR bits (write-1-to-clear / action)
    localparam int CLR_OVR      = 2;
    localparam int CLR_TO       = 3;
    localparam int CLR_FLUSH    = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_if
// CPU register bus between a master and the UART receive controller.
//   reg_req   : request, held by the master until reg_ack
//   reg_we    : 1 = write, 0 = read
//   reg_addr  : byte address, bits [1:0] ignored
//   reg_wdata : write data
//   reg_rdata : read data, valid with reg_ack
//   reg_ack   : one-cycle completion strobe
// ---------------------------------------------------------------------------
interface uart_rx_ctrl_if;
    logic        reg_req;
    logic        reg_we;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport master (
        output reg_req, reg_we, reg_addr, reg_wdata,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_req, reg_we, reg_addr, reg_wdata,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Byte-wide synchronous FIFO with first-word-fall-through output.
//   clk, resetn : clock, synchronous active-low reset
//   push_i      : write din_i (ignored when full unless popping too)
//   pop_i       : drop the head entry (ignored when empty)
//   flush_i     : empty the FIFO; overrides push and pop
//   din_i       : byte to write
//   dout_o      : head entry, valid whenever empty_o = 0
//   count_o     : number of stored entries, 0..DEPTH
//   full_o      : count_o == DEPTH
//   empty_o     : count_o == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [7:0]    din_i,
    output logic [7:0]    dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_pop, do_push;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; a write racing a flush lands in a dead slot.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side UART controller: buffers received bytes in a FIFO and exposes
// DATA / STAT / CTRL / CLR registers on a req/ack register bus, plus a level
// interrupt on fill threshold, overrun, or (optional) line-idle timeout.
//   clk, resetn : clock, synchronous active-low reset
//   rx_data     : byte from the bit-level receiver
//   rx_valid    : one-cycle strobe qualifying rx_data
//   bus         : register bus (uart_rx_ctrl_if.slave)
//   irq         : registered level interrupt
// Build option: define UART_RX_CTRL_TIMEOUT_EN to include the idle-timeout
// counter; otherwise STAT[3]/CTRL[3] read 0 and never interrupt.
// ---------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 208333
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    uart_rx_ctrl_if.slave bus,
    output logic       irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_rx_ctrl: FIFO_DEPTH must be a power of two in 2..64, TIMEOUT_CYCLES >= 1");
    end

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- bus FSM ----------------
    bus_state_e state_q, state_d;
    logic       access;

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // The access fires only on the IDLE->ACK edge, so a request still held
    // during ACK is never executed twice.
    always_comb begin
        state_d = state_q;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.reg_req) begin
                state_d = ST_ACK;
                access  = 1'b1;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.reg_ack = (state_q == ST_ACK);

    // ---------------- decode ----------------
    logic [3:0] off;
    logic       rd_data, wr_ctrl, wr_clr;
    logic       clr_ovr, clr_to, flush;

    assign off     = {bus.reg_addr[3:2], 2'b00};
    assign rd_data = access && !bus.reg_we && (off == OFF_DATA);
    assign wr_ctrl = access &&  bus.reg_we && (off == OFF_CTRL);
    assign wr_clr  = access &&  bus.reg_we && (off == OFF_CLR);
    assign clr_ovr = wr_clr && bus.reg_wdata[CLR_OVR];
    assign clr_to  = wr_clr && bus.reg_wdata[CLR_TO];
    assign flush   = wr_clr && bus.reg_wdata[CLR_FLUSH];

    // ---------------- CTRL ----------------
    logic                   rx_en_q, thr_ie_q, ovr_ie_q, to_ie_q;
    logic [CNT_FIELD_W-1:0] thr_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_en_q  <= 1'b0;
            thr_ie_q <= 1'b0;
            ovr_ie_q <= 1'b0;
            to_ie_q  <= 1'b0;
            thr_q    <= '0;
        end else if (wr_ctrl) begin
            rx_en_q  <= bus.reg_wdata[CTRL_RX_EN];
            thr_ie_q <= bus.reg_wdata[CTRL_THR_IE];
            ovr_ie_q <= bus.reg_wdata[CTRL_OVR_IE];
            to_ie_q  <= TO_EN && bus.reg_wdata[CTRL_TO_IE];
            thr_q    <= bus.reg_wdata[CTRL_THR_LSB +: CNT_FIELD_W];
        end
    end

    // ---------------- FIFO ----------------
    logic          push;
    logic [7:0]    f_dout;
    logic [CW-1:0] f_count;
    logic          f_full, f_empty;

    assign push = rx_valid && rx_en_q;

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push),
        .pop_i   (rd_data),
        .flush_i (flush),
        .din_i   (rx_data),
        .dout_o  (f_dout),
        .count_o (f_count),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    // ---------------- overrun ----------------
    // Full implies non-empty, so a same-cycle DATA read always frees a slot.
    logic ovr_q, ovr_set;
    assign ovr_set = push && f_full && !rd_data;

    always_ff @(posedge clk) begin
        if (!resetn) ovr_q <= 1'b0;
        else         ovr_q <= ovr_set || (ovr_q && !clr_ovr);
    end

    // ---------------- idle timeout ----------------
    logic timeout;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_q, idle_d;
    logic          to_q, to_hit;

    // Counts idle clocks while data waits; parks at TIMEOUT_CYCLES.
    always_comb begin
        idle_d = idle_q;
        to_hit = 1'b0;
        if (push || flush || f_empty) begin
            idle_d = '0;
        end else if (idle_q != TW'(TIMEOUT_CYCLES)) begin
            idle_d = idle_q + 1'b1;
            to_hit = (idle_q == TW'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            idle_q <= '0;
            to_q   <= 1'b0;
        end else begin
            idle_q <= idle_d;
            to_q   <= to_hit || (to_q && !clr_to);
        end
    end

    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    // ---------------- read data / irq ----------------
    logic [31:0] rd_mux, rdata_q;
    logic        irq_q, thr_hit;

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_DATA: if (!f_empty) begin
                rd_mux[7:0]        = f_dout;
                rd_mux[DATA_VALID] = 1'b1;
            end
            OFF_STAT: begin
                rd_mux[STAT_EMPTY] = f_empty;
                rd_mux[STAT_FULL]  = f_full;
                rd_mux[STAT_OVR]   = ovr_q;
                rd_mux[STAT_TO]    = timeout;
                rd_mux[STAT_CNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(f_count);
            end
            OFF_CTRL: begin
                rd_mux[CTRL_RX_EN]  = rx_en_q;
                rd_mux[CTRL_THR_IE] = thr_ie_q;
                rd_mux[CTRL_OVR_IE] = ovr_ie_q;
                rd_mux[CTRL_TO_IE]  = to_ie_q;
                rd_mux[CTRL_THR_LSB +: CNT_FIELD_W] = thr_q;
            end
            default: rd_mux = '0;
        endcase
    end

    // Threshold values above FIFO_DEPTH can never be reached by count.
    assign thr_hit = (CNT_FIELD_W'(f_count) >= thr_q) && (thr_q != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            rdata_q <= access ? rd_mux : '0;
            irq_q   <= (thr_ie_q && thr_hit) || (ovr_ie_q && ovr_q) || (to_ie_q && timeout);
        end
    end

    assign bus.reg_rdata = rdata_q;
    assign irq           = irq_q;

    wire unused_bits = ^{bus.reg_addr[1:0], bus.reg_wdata};

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;
    localparam int TO    = 200;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       irq;
    int         checks = 0;
    int         errors = 0;
    logic [31:0] rd;

    uart_rx_ctrl_if bus_if();

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .bus      (bus_if),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    // Bus master: waits out a pending ACK, then issues one access and expects
    // the ack exactly one edge later.
    task automatic bus_xfer(input logic we, input logic [3:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        int n = 0;
        if (bus_if.reg_ack) begin @(posedge clk); #1; end
        bus_if.reg_we = we; bus_if.reg_addr = addr; bus_if.reg_wdata = wdata;
        bus_if.reg_req = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!bus_if.reg_ack && n < 4);
        checks++;
        if (!bus_if.reg_ack || n != 1) begin
            errors++;
            $display("FAIL bus_ack addr=%h: ack=%b after %0d cycles, required ack=1 after 1", addr, bus_if.reg_ack, n);
        end
        rdata = bus_if.reg_rdata;
        bus_if.reg_req = 1'b0; bus_if.reg_we = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b exp 0", irq); end
        checks++; if (bus_if.reg_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b exp 0", bus_if.reg_ack); end
        checks++; if (bus_if.reg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", bus_if.reg_rdata); end
        resetn = 1'b1;
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL reset_stat: got %h exp 00000001", rd); end
        bus_xfer(1'b0, 4'h8, '0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h exp 0", rd); end
        bus_xfer(1'b0, 4'h0, '0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", rd); end
    endtask

    task automatic test_basic();
        push_byte(8'h11);  // rx disabled: discarded
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rx_disabled_stat: got %h exp 00000001", rd); end
        bus_xfer(1'b1, 4'h8, 32'h1, rd);
        push_byte(8'h55);
        push_byte(8'hAA);
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h200) begin errors++; $display("FAIL basic_stat2: got %h exp 00000200", rd); end
        // Hold the request through ACK: must pop only once.
        go_idle();
        bus_if.reg_we = 1'b0; bus_if.reg_addr = 4'h0; bus_if.reg_req = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus_if.reg_ack !== 1'b1 || bus_if.reg_rdata !== 32'h155) begin
            errors++; $display("FAIL basic_read1: ack=%b data=%h exp ack=1 data=00000155", bus_if.reg_ack, bus_if.reg_rdata); end
        @(posedge clk); #1;
        checks++; if (bus_if.reg_ack !== 1'b0) begin errors++; $display("FAIL held_req_ack: got %b exp 0", bus_if.reg_ack); end
        bus_if.reg_req = 1'b0;
        bus_xfer(1'b0, 4'h0, '0, rd);
        checks++; if (rd !== 32'h1AA) begin errors++; $display("FAIL basic_read2: got %h exp 000001aa", rd); end
        bus_xfer(1'b0, 4'h3, '0, rd);  // low address bits ignored
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL basic_read_empty: got %h exp 0", rd); end
        bus_xfer(1'b1, 4'h0, 32'hFF, rd);  // DATA write ignored
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL basic_stat_empty: got %h exp 00000001", rd); end
        bus_xfer(1'b0, 4'hC, '0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL clr_read: got %h exp 0", rd); end
    endtask

    task automatic test_ctrl_rw();
        logic [31:0] exp;
`ifdef UART_RX_CTRL_TIMEOUT_EN
        exp = 32'h7F0F;
`else
        exp = 32'h7F07;
`endif
        bus_xfer(1'b1, 4'h8, 32'hFFFF_FFFF, rd);
        bus_xfer(1'b0, 4'h8, '0, rd);
        checks++; if (rd !== exp) begin errors++; $display("FAIL ctrl_rw: got %h exp %h", rd, exp); end
        go_idle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr_127_irq: got %b exp 0", irq); end
        bus_xfer(1'b1, 4'h8, 32'h1, rd);
    endtask

    task automatic test_overrun();
        bus_xfer(1'b1, 4'h8, 32'h5, rd);  // rx_en + ovr_ie
        for (int i = 0; i < DEPTH + 1; i++) push_byte(8'h30 + 8'(i));
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovr_irq_early: got %b exp 0", irq); end
        go_idle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovr_irq: got %b exp 1", irq); end
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h1006) begin errors++; $display("FAIL ovr_stat: got %h exp 00001006", rd); end
        // Clear and set of overrun in the same cycle: set wins.
        go_idle();
        bus_if.reg_we = 1'b1; bus_if.reg_addr = 4'hC; bus_if.reg_wdata = 32'h4; bus_if.reg_req = 1'b1;
        rx_data = 8'hEE; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; bus_if.reg_req = 1'b0; bus_if.reg_we = 1'b0;
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h1006) begin errors++; $display("FAIL ovr_set_wins: got %h exp 00001006", rd); end
        bus_xfer(1'b1, 4'hC, 32'h4, rd);
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h1002) begin errors++; $display("FAIL ovr_clear: got %h exp 00001002", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovr_irq_clear: got %b exp 0", irq); end
        for (int i = 0; i < DEPTH; i++) begin
            bus_xfer(1'b0, 4'h0, '0, rd);
            checks++; if (rd !== (32'h130 + 32'(i))) begin
                errors++; $display("FAIL ovr_readback[%0d]: got %h exp %h", i, rd, 32'h130 + 32'(i)); end
        end
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ovr_drained: got %h exp 00000001", rd); end
    endtask

    task automatic test_threshold();
        bus_xfer(1'b1, 4'h8, 32'h3, rd);  // threshold 0 never fires
        push_byte(8'h42);
        go_idle(); go_idle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr_zero_irq: got %b exp 0", irq); end
        bus_xfer(1'b0, 4'h0, '0, rd);
        checks++; if (rd !== 32'h142) begin errors++; $display("FAIL thr_zero_read: got %h exp 00000142", rd); end
        bus_xfer(1'b1, 4'h8, 32'h403, rd);
        for (int i = 1; i <= 4; i++) push_byte(8'h60 + 8'(i));
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr_irq_n1: got %b exp 0", irq); end
        go_idle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL thr_irq_n2: got %b exp 1", irq); end
        bus_xfer(1'b0, 4'h0, '0, rd);
        checks++; if (rd !== 32'h161) begin errors++; $display("FAIL thr_read: got %h exp 00000161", rd); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL thr_irq_hold: got %b exp 1", irq); end
        go_idle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr_irq_fall: got %b exp 0", irq); end
        for (int i = 2; i <= 4; i++) begin
            bus_xfer(1'b0, 4'h0, '0, rd);
            checks++; if (rd !== (32'h160 + 32'(i))) begin
                errors++; $display("FAIL thr_drain[%0d]: got %h exp %h", i, rd, 32'h160 + 32'(i)); end
        end
    endtask

    task automatic test_full_pushpop();
        bus_xfer(1'b1, 4'h8, 32'h1103, rd);  // threshold 17 > depth
        for (int i = 0; i < DEPTH; i++) push_byte(8'h70 + 8'(i));
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h1002) begin errors++; $display("FAIL full_stat: got %h exp 00001002", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thr_above_depth_irq: got %b exp 0", irq); end
        go_idle();
        bus_if.reg_we = 1'b0; bus_if.reg_addr = 4'h0; bus_if.reg_req = 1'b1;
        rx_data = 8'hEE; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; bus_if.reg_req = 1'b0;
        checks++; if (bus_if.reg_ack !== 1'b1 || bus_if.reg_rdata !== 32'h170) begin
            errors++; $display("FAIL full_pushpop_read: ack=%b data=%h exp ack=1 data=00000170", bus_if.reg_ack, bus_if.reg_rdata); end
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h1002) begin errors++; $display("FAIL full_pushpop_stat: got %h exp 00001002", rd); end
        for (int i = 1; i <= DEPTH; i++) begin
            logic [31:0] exp;
            exp = (i == DEPTH) ? 32'h1EE : (32'h170 + 32'(i));
            bus_xfer(1'b0, 4'h0, '0, rd);
            checks++; if (rd !== exp) begin errors++; $display("FAIL full_drain[%0d]: got %h exp %h", i, rd, exp); end
        end
        bus_xfer(1'b1, 4'h8, 32'h1, rd);
    endtask

    task automatic test_empty_pushpop();
        go_idle();
        bus_if.reg_we = 1'b0; bus_if.reg_addr = 4'h0; bus_if.reg_req = 1'b1;
        rx_data = 8'h5A; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; bus_if.reg_req = 1'b0;
        checks++; if (bus_if.reg_rdata !== 32'h0) begin errors++; $display("FAIL empty_pushpop_read: got %h exp 0", bus_if.reg_rdata); end
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h100) begin errors++; $display("FAIL empty_pushpop_stat: got %h exp 00000100", rd); end
        bus_xfer(1'b0, 4'h0, '0, rd);
        checks++; if (rd !== 32'h15A) begin errors++; $display("FAIL empty_pushpop_data: got %h exp 0000015a", rd); end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) push_byte(8'(i));
        go_idle();
        bus_if.reg_we = 1'b1; bus_if.reg_addr = 4'hC; bus_if.reg_wdata = 32'h10; bus_if.reg_req = 1'b1;
        rx_data = 8'h99; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; bus_if.reg_req = 1'b0; bus_if.reg_we = 1'b0;
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL flush_stat: got %h exp 00000001", rd); end
        bus_xfer(1'b0, 4'h0, '0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL flush_data: got %h exp 0", rd); end
    endtask

`ifdef UART_RX_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        bus_xfer(1'b1, 4'h8, 32'h9, rd);  // rx_en + to_ie
        go_idle();
        push_byte(8'h81);
        for (int k = 1; k <= TO - 2; k++) begin
            go_idle();
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL to_early_a[%0d]: got %b exp 0", k, irq); end
        end
        push_byte(8'h82);  // arrives with the idle count at TO-1: restart
        for (int j = 1; j <= TO; j++) begin
            go_idle();
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL to_early_b[%0d]: got %b exp 0", j, irq); end
        end
        go_idle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL to_irq: got %b exp 1", irq); end
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h208) begin errors++; $display("FAIL to_stat: got %h exp 00000208", rd); end
        bus_xfer(1'b0, 4'h0, '0, rd);
        checks++; if (rd !== 32'h181) begin errors++; $display("FAIL to_read1: got %h exp 00000181", rd); end
        bus_xfer(1'b0, 4'h0, '0, rd);
        checks++; if (rd !== 32'h182) begin errors++; $display("FAIL to_read2: got %h exp 00000182", rd); end
        bus_xfer(1'b1, 4'hC, 32'h8, rd);
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL to_clear: got %h exp 00000001", rd); end
        go_idle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL to_irq_clear: got %b exp 0", irq); end
    endtask
`else
    task automatic test_no_timeout();
        bus_xfer(1'b1, 4'h8, 32'hF, rd);
        bus_xfer(1'b0, 4'h8, '0, rd);
        checks++; if (rd !== 32'h7) begin errors++; $display("FAIL no_to_ctrl: got %h exp 00000007", rd); end
        push_byte(8'h81);
        repeat (TO + 5) go_idle();
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h100) begin errors++; $display("FAIL no_to_stat: got %h exp 00000100", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL no_to_irq: got %b exp 0", irq); end
        bus_xfer(1'b0, 4'h0, '0, rd);
        checks++; if (rd !== 32'h181) begin errors++; $display("FAIL no_to_data: got %h exp 00000181", rd); end
    endtask
`endif

    task automatic test_reset_mid();
        bus_xfer(1'b1, 4'h8, 32'h203, rd);  // threshold 2
        for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
        go_idle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_irq: got %b exp 1", irq); end
        bus_if.reg_we = 1'b0; bus_if.reg_addr = 4'h0; bus_if.reg_req = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus_if.reg_ack !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ack: got %b exp 1", bus_if.reg_ack); end
        resetn = 1'b0; bus_if.reg_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus_if.reg_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b exp 0", bus_if.reg_ack); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_mid_irq: got %b exp 0", irq); end
        checks++; if (bus_if.reg_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h exp 0", bus_if.reg_rdata); end
        resetn = 1'b1;
        bus_xfer(1'b0, 4'h4, '0, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rst_mid_stat: got %h exp 00000001", rd); end
        bus_xfer(1'b0, 4'h8, '0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mid_ctrl: got %h exp 0", rd); end
    endtask

    initial begin
        bus_if.reg_req = 1'b0; bus_if.reg_we = 1'b0;
        bus_if.reg_addr = '0;  bus_if.reg_wdata = '0;
        test_reset();
        test_basic();
        test_ctrl_rw();
        test_overrun();
        test_threshold();
        test_full_pushpop();
        test_empty_pushpop();
        test_flush();
`ifdef UART_RX_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the simple UART. It sits between the bit-level receiver (byte + one-cycle valid) and the CPU register bus. It buffers received bytes in a small FIFO and exposes data, status and control registers. It raises a level interrupt on a fill threshold, an overrun, or (optionally) a line-idle timeout.

## Interface
Parameters:
- FIFO_DEPTH, 16, byte entries; power of two, 2..64
- TIMEOUT_CYCLES, 208333, idle clocks after last byte before timeout; default is 4 characters at 9600 baud / 50 MHz

Ports:
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- rx_data  in  8  byte from receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- reg_req  in  1  bus request, held until reg_ack
- reg_we  in  1  1 = write, 0 = read
- reg_addr  in  4  byte address; bits [1:0] ignored
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, valid with reg_ack
- reg_ack  out  1  one-cycle completion strobe
- irq  out  1  level interrupt

## Operation
Registers:
- 0x0 DATA, read: {23'b0, valid, byte}. Pops one entry if the FIFO is non-empty. If empty, returns 0 with valid=0 and does not pop. Writes are ignored.
- 0x4 STAT, read-only: [0] empty, [1] full, [2] overrun, [3] timeout, [14:8] count.
- 0x8 CTRL, read/write: [0] rx_en, [1] thr_ie, [2] ovr_ie, [3] to_ie, [14:8] threshold.
- 0xC CLR, write-1-to-clear: [2] overrun, [3] timeout; also [4] flush, which empties the FIFO. Reads return 0.

Push and overrun:
- Push happens when rx_valid=1 and rx_en=1.
- If rx_en=0, bytes are discarded and no flag is set.
- Push while full: byte dropped, FIFO contents unchanged, overrun set (sticky).

Interrupt:
- irq = (thr_ie && count >= threshold && threshold != 0) || (ovr_ie && overrun) || (to_ie && timeout). Registered.

Bus FSM:
- States: IDLE, ACK.
- IDLE → ACK when reg_req=1. The access is performed on that edge (pop/write/clear), and rdata is captured.
- ACK → IDLE unconditionally. reg_ack=1 in ACK only.
- A request still held in ACK is not re-executed. The master deasserts reg_req on ack.

## Timing
- Reset: all outputs 0. FIFO empty. count=0. CTRL=0 (receive disabled). Flags clear. Bus FSM in IDLE.
- Read latency: request seen in cycle N → reg_ack and reg_rdata in N+1. Pop and count update are visible from N+1.
- Push latency: rx_valid in cycle N → count updated in N+1. irq reflects it in N+2.
- Push and pop in the same cycle: both happen, count unchanged. If full, this is not an overrun, because the pop frees the slot.
- Push and pop on an empty FIFO in the same cycle: the read returns valid=0, and the byte is pushed (no bypass).
- Flush and push in the same cycle: flush wins, FIFO ends empty.
- Clear and set of overrun in the same cycle: set wins.
- Clear and set of timeout in the same cycle: set wins.
- Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits and saturates at FIFO_DEPTH.
- Threshold values above FIFO_DEPTH never fire.
- Reset asserted mid-access: the access is abandoned, no ack is issued, and all state returns to reset values on that edge.

## Configuration
- UART_RX_CTRL_TIMEOUT_EN defined:
  - Idle counter, $clog2(TIMEOUT_CYCLES+1) bits, runs while the FIFO is non-empty.
  - It zeroes on every push, and on flush or on the FIFO becoming empty.
  - On reaching TIMEOUT_CYCLES it sets timeout (sticky) and holds until the next push or empty.
- Not defined: no counter. STAT[3] and CTRL[3] read 0, writes to them are ignored, and the timeout term of irq is 0.

## Structure
- Package uart_pkg holds:
  - register offsets: DATA, STAT, CTRL, CLR;
  - STAT/CTRL/CLR bit-position constants;
  - the bus FSM state enum.
- Sub-module uart_rx_fifo: synchronous FIFO with push/pop/flush, dout, count, full, empty, and first-word-fall-through output.
- The controller instantiates one uart_rx_fifo.

## Test plan
- Reset, then write CTRL=0x0000_0001, push 0x55, 0xAA → STAT count=2. Two DATA reads return 0x155 then 0x1AA. A third read returns 0x000 and STAT reads empty=1.
- FIFO_DEPTH=16: push 17 bytes → count=16, full=1, overrun=1. The 17th byte is absent on read-back. Writing CLR=0x4 clears overrun.
- CTRL threshold=4, thr_ie=1: push 4 bytes → irq rises 2 cycles after the 4th rx_valid. One DATA read → irq falls.
- Full FIFO, rx_valid in the same cycle as the DATA-read request → count stays 16 and overrun stays 0.
- With UART_RX_CTRL_TIMEOUT_EN and to_ie=1: push 1 byte, then idle → timeout and irq assert TIMEOUT_CYCLES cycles after the push, not earlier. A push at TIMEOUT_CYCLES-1 restarts the count.
- Drop resetn for one cycle during ACK and while count=3 → next cycle reg_ack=0, irq=0, count=0, CTRL=0.
